block_data_mem: RTL

- Data-memory responder for the core's load/store path: the far end of the controller's memory-write and result-select signalling.
- Accepts one word-aligned load or store request per transaction over a valid/ready handshake.
- Inserts a parameterised number of wait states, then returns a single-cycle response pulse carrying read data and an error flag.
- Sits between the datapath's ALU-result/rs2 buses and the writeback mux.

---
 rtl/mem_pkg.sv | 13 +
 rtl/block_mem_array.sv | 30 +++
 rtl/block_data_mem.sv | 106 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFF_W = 2;

endpackage

// File: rtl/block_mem_array.sv
// rtl/block_mem_array.sv - word storage with combinational read and byte-enabled synchronous write
module block_mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [WORD_BYTES-1:0] i_be,
  input  logic [IDX_W-1:0]      i_widx,
  input  logic [31:0]           i_wdata,
  input  logic [IDX_W-1:0]      i_ridx,
  output logic [31:0]           o_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents survive reset; only the enabled lanes are touched.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (i_be[k]) mem[i_widx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = mem[i_ridx];

endmodule

// File: rtl/block_data_mem.sv
// rtl/block_data_mem.sv - load/store responder with fixed wait states and a one-cycle response pulse
module block_data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_be,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_INIT_I = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
  localparam logic [3:0] CNT_INIT = 4'(CNT_INIT_I);

  mem_state_t  state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        accept;
  logic        addr_err;
  logic        arr_we;
  logic [31:0] arr_rdata;

  assign accept = (state == IDLE) && i_req_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance so later input churn is ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
    end else if (accept) begin
      cap_we    <= i_we;
      cap_addr  <= i_addr;
      cap_wdata <= i_wdata;
      cap_be    <= i_be;
    end
  end

  assign addr_err = (cap_addr[BYTE_OFF_W-1:0] != '0) ||
                    (cap_addr[31:BYTE_OFF_W] >= 30'(DEPTH_WORDS));

  // Gating with reset keeps a store from landing when reset hits the edge ending RESP.
  assign arr_we = (state == RESP) && cap_we && !addr_err && i_rst_n;

  block_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk  (i_clk),
    .i_we   (arr_we),
    .i_be   (cap_be),
    .i_widx (cap_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
    .i_wdata(cap_wdata),
    .i_ridx (cap_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
    .o_rdata(arr_rdata)
  );

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);
  assign o_err       = (state == RESP) && addr_err;
  assign o_rdata     = ((state == RESP) && !cap_we && !addr_err) ? arr_rdata : 32'd0;

endmodule
